// File: rtl/riscv_defines.sv
// riscv_defines: shared string-operator encodings used by the stream engine and the str-op unit.
package riscv_defines;

    localparam int unsigned STR_OP_WIDTH = 2;

    localparam logic [STR_OP_WIDTH-1:0] STR_OP_NONE  = 2'd0;
    localparam logic [STR_OP_WIDTH-1:0] STR_OP_UPPER = 2'd1;
    localparam logic [STR_OP_WIDTH-1:0] STR_OP_LOWER = 2'd2;
    localparam logic [STR_OP_WIDTH-1:0] STR_OP_LEET  = 2'd3;

endpackage

// File: rtl/riscv_str_stream.sv
// riscv_str_stream: word-at-a-time string engine; reads src, transforms via the str-op unit, writes dst until a zero byte or the word limit.
//   clk, rst_n                  clock, asynchronous active-low reset
//   start_i, operator_i         begin request and string operator (captured in IDLE)
//   src_addr_i, dst_addr_i      word-aligned byte addresses (low two bits dropped)
//   max_words_i                 word limit (0 completes immediately)
//   busy_o, done_o, count_o     engine active, completion pulse, words written
//   data_*                      single-outstanding memory port (req/gnt, then rvalid)
//   strop_*                     handshake with the external str-op unit
module riscv_str_stream
    import riscv_defines::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start_i,
    input  logic [STR_OP_WIDTH-1:0] operator_i,
    input  logic [31:0]             src_addr_i,
    input  logic [31:0]             dst_addr_i,
    input  logic [7:0]              max_words_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic [7:0]              count_o,
    output logic                    data_req_o,
    output logic                    data_we_o,
    output logic [31:0]             data_addr_o,
    output logic [31:0]             data_wdata_o,
    output logic [3:0]              data_be_o,
    input  logic                    data_gnt_i,
    input  logic                    data_rvalid_i,
    input  logic [31:0]             data_rdata_i,
    output logic                    strop_enable_o,
    output logic [STR_OP_WIDTH-1:0] strop_operator_o,
    output logic [31:0]             strop_operand_o,
    input  logic [31:0]             strop_result_i,
    input  logic                    strop_ready_i
);

    typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, OP, WR_REQ, WR_WAIT, DONE} state_e;

    state_e                  state_q, state_d;
    logic [31:0]             src_q, dst_q, operand_q, result_q;
    logic [STR_OP_WIDTH-1:0] op_q;
    logic [7:0]              max_q, count_q;
    logic                    last_q, has_zero;

    assign has_zero = (data_rdata_i[7:0] == 8'd0) || (data_rdata_i[15:8] == 8'd0) ||
                      (data_rdata_i[23:16] == 8'd0) || (data_rdata_i[31:24] == 8'd0);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_i) state_d = (max_words_i == 8'd0) ? DONE : RD_REQ;
            RD_REQ:  if (data_gnt_i) state_d = RD_WAIT;
            RD_WAIT: if (data_rvalid_i) state_d = OP;
            OP:      if (strop_ready_i) state_d = WR_REQ;
            WR_REQ:  if (data_gnt_i) state_d = WR_WAIT;
            WR_WAIT: if (data_rvalid_i) state_d = last_q ? DONE : RD_REQ;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            src_q     <= '0;
            dst_q     <= '0;
            operand_q <= '0;
            result_q  <= '0;
            op_q      <= '0;
            max_q     <= '0;
            count_q   <= '0;
            last_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: if (start_i) begin
                    op_q    <= operator_i;
                    src_q   <= {src_addr_i[31:2], 2'b00};
                    dst_q   <= {dst_addr_i[31:2], 2'b00};
                    max_q   <= max_words_i;
                    count_q <= '0;
                    last_q  <= 1'b0;
                end
                // The final word is known at read time: a terminator byte or the limit being reached.
                RD_WAIT: if (data_rvalid_i) begin
                    operand_q <= data_rdata_i;
                    last_q    <= has_zero || (count_q + 8'd1 == max_q);
                end
                OP: if (strop_ready_i) result_q <= strop_result_i;
                WR_WAIT: if (data_rvalid_i) begin
                    count_q <= count_q + 8'd1;
                    src_q   <= src_q + 32'd4;
                    dst_q   <= dst_q + 32'd4;
                end
                default: ;
            endcase
        end
    end

    assign busy_o           = state_q != IDLE;
    assign done_o           = state_q == DONE;
    assign count_o          = count_q;
    assign data_req_o       = (state_q == RD_REQ) || (state_q == WR_REQ);
    assign data_we_o        = state_q == WR_REQ;
    assign data_addr_o      = (state_q == WR_REQ) ? dst_q : src_q;
    assign data_wdata_o     = result_q;
    assign data_be_o        = data_req_o ? 4'hF : 4'h0;
    assign strop_enable_o   = state_q == OP;
    assign strop_operator_o = op_q;
    assign strop_operand_o  = operand_q;

endmodule

// File: tb/tb_riscv_str_stream.sv
// tb_riscv_str_stream: directed self-checking bench with a memory responder and str-op unit responder.
module tb_riscv_str_stream;
    import riscv_defines::*;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    start_i;
    logic [STR_OP_WIDTH-1:0] operator_i;
    logic [31:0]             src_addr_i, dst_addr_i;
    logic [7:0]              max_words_i;
    logic                    busy_o, done_o;
    logic [7:0]              count_o;
    logic                    data_req_o, data_we_o;
    logic [31:0]             data_addr_o, data_wdata_o;
    logic [3:0]              data_be_o;
    logic                    data_gnt_i, data_rvalid_i;
    logic [31:0]             data_rdata_i;
    logic                    strop_enable_o;
    logic [STR_OP_WIDTH-1:0] strop_operator_o;
    logic [31:0]             strop_operand_o, strop_result_i;
    logic                    strop_ready_i;

    riscv_str_stream dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .operator_i(operator_i),
        .src_addr_i(src_addr_i), .dst_addr_i(dst_addr_i), .max_words_i(max_words_i),
        .busy_o(busy_o), .done_o(done_o), .count_o(count_o),
        .data_req_o(data_req_o), .data_we_o(data_we_o), .data_addr_o(data_addr_o),
        .data_wdata_o(data_wdata_o), .data_be_o(data_be_o), .data_gnt_i(data_gnt_i),
        .data_rvalid_i(data_rvalid_i), .data_rdata_i(data_rdata_i),
        .strop_enable_o(strop_enable_o), .strop_operator_o(strop_operator_o),
        .strop_operand_o(strop_operand_o), .strop_result_i(strop_result_i),
        .strop_ready_i(strop_ready_i)
    );

    always #5 clk = ~clk;

    int          checks = 0, failures = 0;
    logic [31:0] mem [256];
    logic [31:0] wr_addr[$], wr_data[$], rd_addr[$];
    int          gnt_delay = 0, rdy_delay = 0;
    int          done_cnt = 0, req_cnt = 0, unstable = 0;
    int          wb, rb, db, qb;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] strop_model(input logic [STR_OP_WIDTH-1:0] op, input logic [31:0] w);
        logic [31:0] r = w;
        for (int i = 0; i < 4; i++) begin
            logic [7:0] b = w[8*i +: 8];
            if (op == STR_OP_UPPER && b >= 8'h61 && b <= 8'h7a) b = b - 8'h20;
            else if (op == STR_OP_LOWER && b >= 8'h41 && b <= 8'h5a) b = b + 8'h20;
            else if (op == STR_OP_LEET)
                b = (b == 8'h61) ? 8'h34 : (b == 8'h65) ? 8'h33 : (b == 8'h69) ? 8'h31 :
                    (b == 8'h6f) ? 8'h30 : (b == 8'h73) ? 8'h35 : (b == 8'h74) ? 8'h37 : b;
            r[8*i +: 8] = b;
        end
        return r;
    endfunction

    // Memory: grant after gnt_delay cycles of held request, rvalid the cycle after the grant.
    initial begin
        int          gcnt = 0;
        logic        pending = 1'b0, hold = 1'b0, hwe = 1'b0;
        logic [31:0] ha = '0, hw = '0, rdat = '0;
        data_gnt_i = 1'b0; data_rvalid_i = 1'b0; data_rdata_i = '0;
        forever begin
            @(posedge clk); #1;
            data_gnt_i = 1'b0; data_rvalid_i = 1'b0;
            if (done_o) done_cnt++;
            if (data_req_o) req_cnt++;
            if (!rst_n) begin
                pending = 1'b0; hold = 1'b0; gcnt = 0;
            end else if (pending) begin
                data_rvalid_i = 1'b1; data_rdata_i = rdat; pending = 1'b0;
            end else if (data_req_o) begin
                if (hold && (data_addr_o != ha || data_wdata_o != hw || data_we_o != hwe)) unstable++;
                if (!hold) begin hold = 1'b1; ha = data_addr_o; hw = data_wdata_o; hwe = data_we_o; end
                if (data_be_o != 4'hF) unstable++;
                if (gcnt < gnt_delay) gcnt++;
                else begin
                    data_gnt_i = 1'b1; gcnt = 0; hold = 1'b0; pending = 1'b1;
                    if (data_we_o) begin
                        wr_addr.push_back(data_addr_o); wr_data.push_back(data_wdata_o); rdat = '0;
                    end else begin
                        rd_addr.push_back(data_addr_o); rdat = mem[data_addr_o[9:2]];
                    end
                end
            end
        end
    end

    // Str-op unit: ready after rdy_delay cycles of enable; operand must hold while waiting.
    initial begin
        int          scnt = 0;
        logic        shold = 1'b0;
        logic [31:0] so = '0;
        strop_ready_i = 1'b0; strop_result_i = '0;
        forever begin
            @(posedge clk); #1;
            strop_ready_i = 1'b0;
            if (strop_enable_o && rst_n) begin
                if (shold && strop_operand_o != so) unstable++;
                so = strop_operand_o; shold = 1'b1;
                if (scnt < rdy_delay) scnt++;
                else begin
                    strop_ready_i = 1'b1;
                    strop_result_i = strop_model(strop_operator_o, strop_operand_o);
                end
            end else begin
                scnt = 0; shold = 1'b0;
            end
        end
    end

    task automatic start_op(input logic [31:0] s, input logic [31:0] d, input logic [7:0] m,
                            input logic [STR_OP_WIDTH-1:0] op, input int gd, input int rd);
        gnt_delay = gd; rdy_delay = rd;
        wb = wr_addr.size(); rb = rd_addr.size(); db = done_cnt; qb = req_cnt;
        @(posedge clk); #1;
        start_i = 1'b1; src_addr_i = s; dst_addr_i = d; max_words_i = m; operator_i = op;
        @(posedge clk); #1;
        start_i = 1'b0; src_addr_i = '0; dst_addr_i = '0; max_words_i = '0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (done_cnt == db && n < 3000) begin @(posedge clk); #2; n++; end
        repeat (4) @(posedge clk);
        #2;
        check({tag, "_done_once"}, 32'(done_cnt - db), 32'd1);
        check({tag, "_idle"}, {31'd0, busy_o}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; start_i = 1'b0; operator_i = STR_OP_NONE;
        src_addr_i = '0; dst_addr_i = '0; max_words_i = '0;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        #23;
        check("rst_busy", {31'd0, busy_o}, 32'd0);
        check("rst_done", {31'd0, done_o}, 32'd0);
        check("rst_count", {24'd0, count_o}, 32'd0);
        check("rst_req", {31'd0, data_req_o}, 32'd0);
        check("rst_en", {31'd0, strop_enable_o}, 32'd0);
        check("rst_addr", data_addr_o, 32'd0);
        rst_n = 1'b1;

        // Two-word uppercase run ending on a terminator word.
        mem[8'h40] = 32'h64636261; mem[8'h41] = 32'h00006665;
        start_op(32'h100, 32'h200, 8'd8, STR_OP_UPPER, 0, 0);
        wait_done("up");
        check("up_writes", 32'(wr_addr.size() - wb), 32'd2);
        check("up_wa0", wr_addr[wb], 32'h200);
        check("up_wd0", wr_data[wb], 32'h44434241);
        check("up_wa1", wr_addr[wb+1], 32'h204);
        check("up_wd1", wr_data[wb+1], 32'h00004645);
        check("up_count", {24'd0, count_o}, 32'd2);
        check("up_ra1", rd_addr[rb+1], 32'h104);

        // Zero word limit: done next cycle, no memory traffic.
        start_op(32'h100, 32'h200, 8'd0, STR_OP_UPPER, 0, 0);
        check("zero_done_next", {31'd0, done_o}, 32'd1);
        wait_done("zero");
        check("zero_count", {24'd0, count_o}, 32'd0);
        check("zero_no_req", 32'(req_cnt - qb), 32'd0);

        // Word limit stops a string without terminator.
        mem[8'hC0] = 32'h61626364; mem[8'hC1] = 32'h65666768;
        mem[8'hC2] = 32'h696a6b6c; mem[8'hC3] = 32'h6d6e6f70;
        start_op(32'h300, 32'h320, 8'd3, STR_OP_UPPER, 0, 0);
        wait_done("lim");
        check("lim_reads", 32'(rd_addr.size() - rb), 32'd3);
        check("lim_writes", 32'(wr_addr.size() - wb), 32'd3);
        check("lim_count", {24'd0, count_o}, 32'd3);
        check("lim_wd0", wr_data[wb], 32'h41424344);
        check("lim_wd2", wr_data[wb+2], 32'h494a4b4c);
        check("lim_wa2", wr_addr[wb+2], 32'h328);

        // Slow grant and slow str-op unit with leet substitution.
        mem[8'h50] = 32'h74736561; mem[8'h51] = 32'h00000000;
        start_op(32'h140, 32'h240, 8'd8, STR_OP_LEET, 5, 3);
        wait_done("slow");
        check("slow_wd0", wr_data[wb], 32'h37353334);
        check("slow_wd1", wr_data[wb+1], 32'h00000000);
        check("slow_wa1", wr_addr[wb+1], 32'h244);
        check("slow_count", {24'd0, count_o}, 32'd2);
        check("stable", 32'(unstable), 32'd0);

        // Source address wraps past the top of memory; low bits ignored.
        mem[8'hFF] = 32'h61616161; mem[8'h00] = 32'h62626262;
        start_op(32'hFFFFFFFE, 32'h380, 8'd2, STR_OP_UPPER, 0, 0);
        wait_done("wrap");
        check("wrap_ra0", rd_addr[rb], 32'hFFFFFFFC);
        check("wrap_ra1", rd_addr[rb+1], 32'h00000000);
        check("wrap_wd1", wr_data[wb+1], 32'h42424242);
        check("wrap_count", {24'd0, count_o}, 32'd2);

        // Reset during the second write's wait state.
        mem[8'h60] = 32'h61626364; mem[8'h61] = 32'h61626364; mem[8'h62] = 32'h61626364;
        start_op(32'h180, 32'h280, 8'd3, STR_OP_UPPER, 0, 0);
        begin
            int n = 0;
            while (wr_addr.size() < wb + 2 && n < 200) begin @(posedge clk); #2; n++; end
        end
        check("mid_reached", 32'(wr_addr.size() - wb), 32'd2);
        @(posedge clk); #3;
        check("mid_count_pre", {24'd0, count_o}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_busy", {31'd0, busy_o}, 32'd0);
        check("mid_count", {24'd0, count_o}, 32'd0);
        check("mid_req", {31'd0, data_req_o}, 32'd0);
        check("mid_done", {31'd0, done_o}, 32'd0);
        check("mid_addr", data_addr_o, 32'd0);
        db = done_cnt;
        repeat (2) @(posedge clk);
        #5 rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #2;
        check("mid_no_done", 32'(done_cnt - db), 32'd0);
        start_op(32'h100, 32'h500, 8'd8, STR_OP_UPPER, 0, 0);
        wait_done("post");
        check("post_writes", 32'(wr_addr.size() - wb), 32'd2);
        check("post_wa0", wr_addr[wb], 32'h500);
        check("post_wd1", wr_data[wb+1], 32'h00004645);
        check("post_count", {24'd0, count_o}, 32'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/riscv_str_stream.md
RISCV_STR_STREAM -- requirements
Module: riscv_str_stream

Interface
REQ-001 SHALL have port clk, input, 1, clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port start_i, input, 1, one-cycle request to begin a string operation.
REQ-004 SHALL have port operator_i, input, STR_OP_WIDTH, string operator, captured on accepted start.
REQ-005 SHALL have ports src_addr_i / dst_addr_i, input, 32 each, source/destination byte addresses, captured on start; bits [1:0] forced to 0.
REQ-006 SHALL have port max_words_i, input, 8, word limit, captured on start.
REQ-007 SHALL have ports busy_o (1), done_o (1), count_o (8), all outputs: engine active; one-cycle completion pulse; words written.
REQ-008 SHALL have memory ports data_req_o, data_we_o, data_addr_o[31:0], data_wdata_o[31:0], data_be_o[3:0] (out) and data_gnt_i, data_rvalid_i, data_rdata_i[31:0] (in).
REQ-009 SHALL have str-op ports strop_enable_o, strop_operator_o[STR_OP_WIDTH-1:0], strop_operand_o[31:0] (out) and strop_result_i[31:0], strop_ready_i (in).

Function
REQ-010 FSM states SHALL be IDLE, RD_REQ, RD_WAIT, OP, WR_REQ, WR_WAIT, DONE.
REQ-011 IDLE: start_i=1 with max_words_i!=0 -> RD_REQ, count cleared; max_words_i=0 -> DONE, count_o=0, no memory access.
REQ-012 start_i SHALL be ignored in every state except IDLE.
REQ-013 RD_REQ: data_req_o=1, data_we_o=0, data_addr_o=current src; held stable until data_gnt_i; on gnt -> RD_WAIT.
REQ-014 RD_WAIT: on data_rvalid_i, capture data_rdata_i into operand register, latch last flag = (any byte of rdata equals 0) OR (count+1 == max_words) -> OP.
REQ-015 OP: strop_enable_o=1, operand/operator stable; in first cycle with strop_ready_i=1 capture strop_result_i -> WR_REQ; minimum one cycle in OP.
REQ-016 strop_enable_o SHALL be 0 in every state other than OP.
REQ-017 WR_REQ: data_req_o=1, data_we_o=1, data_be_o=4'hF, addr=current dst, wdata=captured result; held until gnt -> WR_WAIT.
REQ-018 WR_WAIT: on data_rvalid_i increment count, src/dst += 4 (mod 2^32 wrap); last flag set -> DONE, else -> RD_REQ.
REQ-019 DONE: done_o=1 for exactly one cycle -> IDLE; count_o holds final value until next accepted start.
REQ-020 busy_o SHALL be 1 in every state except IDLE.
REQ-021 data_req_o SHALL be 0 outside RD_REQ/WR_REQ; at most one outstanding memory transaction.
REQ-022 Word containing the zero terminator SHALL be processed and written (count includes it).
REQ-023 gnt and rvalid in the same cycle as req SHALL not skip the wait state (rvalid accepted only in *_WAIT).

Reset
REQ-024 rst_n low SHALL asynchronously force IDLE, count_o=0, done_o=0, busy_o=0, data_req_o=0, strop_enable_o=0, address/operand registers 0.
REQ-025 Reset mid-operation SHALL abandon the transfer; no done_o pulse after release.

Structure
REQ-026 STR_OP_WIDTH and STR_OP_* constants SHALL come from riscv_defines; FSM enum local to module.
REQ-027 No sub-module; zero-byte detect inline; riscv_str_ops instantiated by parent, connected to strop_* ports.

Verification
REQ-028 Src @0x100 = 0x64636261, 0x00006665, op UPPER, max 8, gnt/rvalid next cycle -> writes 0x44434241, 0x00004645 to dst 0x200/0x204, count_o=2, one done_o pulse.
REQ-029 max_words_i=0 with start -> done_o next cycle, count_o=0, data_req_o never asserted.
REQ-030 No zero bytes, max_words_i=3 -> exactly 3 reads, 3 writes, count_o=3.
REQ-031 gnt delayed 5 cycles, strop_ready_i low 3 cycles (LEET) -> addr/wdata/operand stable throughout, correct results.
REQ-032 src_addr_i=0xFFFFFFFC, 2 words -> second read at 0x00000000.
REQ-033 rst_n low during WR_WAIT -> all outputs at reset values immediately; start after release runs cleanly.
